// File: rtl/addr_decoder.sv
// Cache address splitter: slices a byte address into tag / line index / word select / byte offset,
// with a one-cycle registered copy (plus valid and misalignment flags) for the cache controller.
module addr_decoder #(
  parameter  int unsigned ADDR_W   = 16,
  parameter  int unsigned INDEX_W  = 5,
  parameter  int unsigned OFFSET_W = 5,
  localparam int unsigned TAG_W    = ADDR_W - INDEX_W - OFFSET_W,
  localparam int unsigned WSEL_W   = OFFSET_W - 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [ADDR_W-1:0]   addr,
  input  logic                addr_valid,
  output logic [TAG_W-1:0]    tag,
  output logic [INDEX_W-1:0]  index,
  output logic [WSEL_W-1:0]   word_sel,
  output logic [1:0]          byte_off,
  output logic [TAG_W-1:0]    tag_q,
  output logic [INDEX_W-1:0]  index_q,
  output logic [WSEL_W-1:0]   word_sel_q,
  output logic                misaligned_q,
  output logic                out_valid
);

  // Reject field maps that leave no tag bits or no room for a word select.
  if (ADDR_W < INDEX_W + OFFSET_W + 1) begin : g_bad_tag
    $error("addr_decoder: TAG_W must be >= 1");
  end
  if (OFFSET_W < 3) begin : g_bad_offset
    $error("addr_decoder: OFFSET_W must be >= 3");
  end

  // Pure bit slices for same-cycle tag/valid array lookup.
  assign tag      = addr[ADDR_W-1 -: TAG_W];
  assign index    = addr[INDEX_W+OFFSET_W-1 -: INDEX_W];
  assign word_sel = addr[OFFSET_W-1 -: WSEL_W];
  assign byte_off = addr[1:0];

  // Fields are captured only on valid cycles; out_valid tracks addr_valid every cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_q        <= '0;
      index_q      <= '0;
      word_sel_q   <= '0;
      misaligned_q <= 1'b0;
      out_valid    <= 1'b0;
    end else begin
      out_valid <= addr_valid;
      if (addr_valid) begin
        tag_q        <= tag;
        index_q      <= index;
        word_sel_q   <= word_sel;
        misaligned_q <= |byte_off;
      end
    end
  end

endmodule

// File: tb/tb_addr_decoder.sv
// Directed, table-driven check of addr_decoder field slicing, registered stage, hold and async reset.
module tb_addr_decoder;

  logic        clk;
  logic        rst_n;
  logic [15:0] addr;
  logic        addr_valid;
  logic [5:0]  tag;
  logic [4:0]  index;
  logic [2:0]  word_sel;
  logic [1:0]  byte_off;
  logic [5:0]  tag_q;
  logic [4:0]  index_q;
  logic [2:0]  word_sel_q;
  logic        misaligned_q;
  logic        out_valid;

  int pass_cnt = 0;
  int total    = 0;

  addr_decoder dut (
    .clk(clk), .rst_n(rst_n), .addr(addr), .addr_valid(addr_valid),
    .tag(tag), .index(index), .word_sel(word_sel), .byte_off(byte_off),
    .tag_q(tag_q), .index_q(index_q), .word_sel_q(word_sel_q),
    .misaligned_q(misaligned_q), .out_valid(out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a;
    logic        v;
    logic [5:0]  t;
    logic [4:0]  i;
    logic [2:0]  w;
    logic [1:0]  b;
    logic        ov;
    logic [5:0]  tq;
    logic [4:0]  iq;
    logic [2:0]  wq;
    logic        mq;
  } vec_t;

  vec_t vecs [9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic chk_regs(input string tagname, input logic ov, input logic [5:0] tq,
                          input logic [4:0] iq, input logic [2:0] wq, input logic mq);
    chk({tagname, " out_valid"},    32'(out_valid),    32'(ov));
    chk({tagname, " tag_q"},        32'(tag_q),        32'(tq));
    chk({tagname, " index_q"},      32'(index_q),      32'(iq));
    chk({tagname, " word_sel_q"},   32'(word_sel_q),   32'(wq));
    chk({tagname, " misaligned_q"}, 32'(misaligned_q), 32'(mq));
  endtask

  initial begin
    //          addr      v     tag    idx    ws    bo     ov    tq     iq     wq    mq
    vecs[0] = '{16'hABCD, 1'b1, 6'h2A, 5'h1E, 3'd3, 2'd1, 1'b1, 6'h2A, 5'h1E, 3'd3, 1'b1};
    vecs[1] = '{16'h1234, 1'b1, 6'h04, 5'h11, 3'd5, 2'd0, 1'b1, 6'h04, 5'h11, 3'd5, 1'b0};
    vecs[2] = '{16'hFFFF, 1'b1, 6'h3F, 5'h1F, 3'd7, 2'd3, 1'b1, 6'h3F, 5'h1F, 3'd7, 1'b1};
    vecs[3] = '{16'h0000, 1'b1, 6'h00, 5'h00, 3'd0, 2'd0, 1'b1, 6'h00, 5'h00, 3'd0, 1'b0};
    vecs[4] = '{16'h5555, 1'b1, 6'h15, 5'h0A, 3'd5, 2'd1, 1'b1, 6'h15, 5'h0A, 3'd5, 1'b1};
    vecs[5] = '{16'h0000, 1'b0, 6'h00, 5'h00, 3'd0, 2'd0, 1'b0, 6'h15, 5'h0A, 3'd5, 1'b1};
    vecs[6] = '{16'h1234, 1'b1, 6'h04, 5'h11, 3'd5, 2'd0, 1'b1, 6'h04, 5'h11, 3'd5, 1'b0};
    vecs[7] = '{16'hABCD, 1'b1, 6'h2A, 5'h1E, 3'd3, 2'd1, 1'b1, 6'h2A, 5'h1E, 3'd3, 1'b1};
    vecs[8] = '{16'h5555, 1'b1, 6'h15, 5'h0A, 3'd5, 2'd1, 1'b1, 6'h15, 5'h0A, 3'd5, 1'b1};

    rst_n      = 1'b1;
    addr       = 16'h0000;
    addr_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_regs("reset", 1'b0, 6'h00, 5'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1 chk_regs("reset held", 1'b0, 6'h00, 5'h00, 3'd0, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;

    // Vectors are applied on consecutive edges, so rows 6..8 form a back-to-back stream.
    for (int n = 0; n < 9; n++) begin
      @(negedge clk);
      addr       = vecs[n].a;
      addr_valid = vecs[n].v;
      #1;
      chk($sformatf("v%0d tag", n),      32'(tag),      32'(vecs[n].t));
      chk($sformatf("v%0d index", n),    32'(index),    32'(vecs[n].i));
      chk($sformatf("v%0d word_sel", n), 32'(word_sel), 32'(vecs[n].w));
      chk($sformatf("v%0d byte_off", n), 32'(byte_off), 32'(vecs[n].b));
      @(posedge clk);
      #1 chk_regs($sformatf("v%0d", n), vecs[n].ov, vecs[n].tq, vecs[n].iq, vecs[n].wq, vecs[n].mq);
    end

    // Async reset between edges while out_valid=1; combinational fields keep tracking addr.
    @(negedge clk);
    addr       = 16'hABCD;
    addr_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1 chk_regs("async rst", 1'b0, 6'h00, 5'h00, 3'd0, 1'b0);
    chk("async rst tag",   32'(tag),   32'(6'h2A));
    chk("async rst index", 32'(index), 32'(5'h1E));
    addr = 16'hFFFF;
    #1 chk("rst track tag", 32'(tag), 32'(6'h3F));
    chk("rst track word_sel", 32'(word_sel), 32'(3'd7));
    @(posedge clk);
    #1 chk_regs("rst edge", 1'b0, 6'h00, 5'h00, 3'd0, 1'b0);

    // First capture after release happens on the next rising edge, not before.
    @(negedge clk);
    rst_n = 1'b1;
    addr  = 16'h1234;
    #1 chk_regs("post rst pre-edge", 1'b0, 6'h00, 5'h00, 3'd0, 1'b0);
    @(posedge clk);
    #1 chk_regs("post rst capture", 1'b1, 6'h04, 5'h11, 3'd5, 1'b0);

    @(negedge clk);
    addr_valid = 1'b0;
    addr       = 16'hFFFF;
    @(posedge clk);
    #1 chk_regs("final hold", 1'b0, 6'h04, 5'h11, 3'd5, 1'b0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
